// File: rtl/sp_ram_banked_pm.sv
// Banked single-port RAM with req/gnt/rvalid handshake, optional output register
// and per-bank idle sleep with on-demand wake.
//
// state     | meaning
// ST_SLEEP  | bank in retention, contents kept, not accessible
// ST_WAKE   | bank powering up for WAKE_CYCLES cycles, not accessible
// ST_ACTIVE | bank accessible, idle counter running
module sp_ram_banked_pm #(
   parameter int  RAM_SIZE    = 32768,
   parameter int  DATA_WIDTH  = 32,
   parameter int  BANK_DEPTH  = 2048,
   parameter int  OUT_REG     = 0,
   parameter int  IDLE_CYCLES = 16,
   parameter int  WAKE_CYCLES = 2,
   localparam int NUM_BYTES   = DATA_WIDTH / 8,
   localparam int BANK_COUNT  = RAM_SIZE / (BANK_DEPTH * NUM_BYTES),
   localparam int ADDR_WIDTH  = $clog2(RAM_SIZE)
) (
   input  logic                  clk,
   input  logic                  rst_i,
   input  logic                  req_i,
   output logic                  gnt_o,
   input  logic [ADDR_WIDTH-1:0] addr_i,
   input  logic                  we_i,
   input  logic [NUM_BYTES-1:0]  be_i,
   input  logic [DATA_WIDTH-1:0] wdata_i,
   output logic                  rvalid_o,
   output logic [DATA_WIDTH-1:0] rdata_o,
   output logic [BANK_COUNT-1:0] bank_awake_o
);

   localparam int BYTE_BITS = $clog2(NUM_BYTES);
   localparam int BANK_BITS = (BANK_COUNT > 1) ? $clog2(BANK_COUNT) : 1;
   localparam int IDX_W     = ADDR_WIDTH - BYTE_BITS;
   localparam int WORDS     = RAM_SIZE / NUM_BYTES;
   localparam int IDLE_W    = (IDLE_CYCLES > 1) ? $clog2(IDLE_CYCLES) : 1;
   localparam int WAKE_W    = (WAKE_CYCLES > 1) ? $clog2(WAKE_CYCLES) : 1;
   localparam logic [IDLE_W-1:0] IDLE_TC = IDLE_W'((IDLE_CYCLES > 0) ? IDLE_CYCLES - 1 : 0);
   localparam logic [WAKE_W-1:0] WAKE_LD = WAKE_W'(WAKE_CYCLES - 1);

   typedef enum logic [1:0] {
      ST_SLEEP  = 2'd0,
      ST_WAKE   = 2'd1,
      ST_ACTIVE = 2'd2
   } bank_st_e;

   bank_st_e              st_q   [BANK_COUNT];
   logic [IDLE_W-1:0]     idle_q [BANK_COUNT];
   logic [WAKE_W-1:0]     wake_q [BANK_COUNT];
   logic [BANK_COUNT-1:0] awake;
   logic [BANK_COUNT-1:0] bank_hit;
   logic [BANK_BITS-1:0]  bank_sel;
   logic                  tgt_active;
   logic [IDX_W-1:0]      idx;
   logic                  rd_gnt;
   logic                  wr_gnt;

   // Bank field sits directly above the word field, so the flat word index is
   // simply the address without its byte-lane bits.
   assign idx = addr_i[ADDR_WIDTH-1:BYTE_BITS];

   generate
      if (BANK_COUNT > 1) begin : g_multi
         assign bank_sel   = addr_i[ADDR_WIDTH-1 -: BANK_BITS];
         assign tgt_active = awake[bank_sel];
      end else begin : g_single
         assign bank_sel   = '0;
         assign tgt_active = awake[0];
      end
      if (BYTE_BITS > 0) begin : g_lsb
         logic unused_lsb;
         assign unused_lsb = ^addr_i[BYTE_BITS-1:0];
      end
   endgenerate

   always_comb begin
      awake    = '0;
      bank_hit = '0;
      for (int b = 0; b < BANK_COUNT; b++) begin
         awake[b]    = (st_q[b] == ST_ACTIVE);
         bank_hit[b] = req_i && (bank_sel == BANK_BITS'(b));
      end
   end

   assign gnt_o        = req_i && tgt_active;
   assign rd_gnt       = gnt_o && !we_i && !rst_i;
   assign wr_gnt       = gnt_o && we_i && !rst_i;
   assign bank_awake_o = awake;

   always_ff @(posedge clk) begin
      for (int b = 0; b < BANK_COUNT; b++) begin
         if (rst_i) begin
            st_q[b]   <= ST_ACTIVE;
            idle_q[b] <= '0;
            wake_q[b] <= '0;
         end else begin
            unique case (st_q[b])
               ST_ACTIVE: begin
                  // A request to an ACTIVE bank is always granted, so a hit is an access.
                  if (bank_hit[b]) begin
                     idle_q[b] <= '0;
                  end else if ((IDLE_CYCLES != 0) && (idle_q[b] == IDLE_TC)) begin
                     st_q[b] <= ST_SLEEP;
                  end else if (idle_q[b] != IDLE_TC) begin
                     idle_q[b] <= idle_q[b] + IDLE_W'(1);
                  end
               end
               ST_SLEEP: begin
                  if (bank_hit[b]) begin
                     st_q[b]   <= ST_WAKE;
                     wake_q[b] <= WAKE_LD;
                  end
               end
               ST_WAKE: begin
                  if (wake_q[b] == '0) begin
                     st_q[b]   <= ST_ACTIVE;
                     idle_q[b] <= '0;
                  end else begin
                     wake_q[b] <= wake_q[b] - WAKE_W'(1);
                  end
               end
               default: st_q[b] <= ST_ACTIVE;
            endcase
         end
      end
   end

   logic [DATA_WIDTH-1:0] mem_q [WORDS];

   always_ff @(posedge clk) begin
      if (wr_gnt) begin
         for (int k = 0; k < NUM_BYTES; k++) begin
            if (be_i[k]) begin
               mem_q[idx][8*k +: 8] <= wdata_i[8*k +: 8];
            end
         end
      end
   end

   logic                  rv1_q;
   logic [DATA_WIDTH-1:0] rd1_q;

   always_ff @(posedge clk) begin
      if (rst_i) begin
         rv1_q <= 1'b0;
         rd1_q <= '0;
      end else begin
         rv1_q <= rd_gnt;
         if (rd_gnt) begin
            rd1_q <= mem_q[idx];
         end
      end
   end

   generate
      if (OUT_REG != 0) begin : g_oreg
         logic                  rv2_q;
         logic [DATA_WIDTH-1:0] rd2_q;
         always_ff @(posedge clk) begin
            if (rst_i) begin
               rv2_q <= 1'b0;
               rd2_q <= '0;
            end else begin
               rv2_q <= rv1_q;
               if (rv1_q) begin
                  rd2_q <= rd1_q;
               end
            end
         end
         assign rvalid_o = rv2_q;
         assign rdata_o  = rd2_q;
      end else begin : g_noreg
         assign rvalid_o = rv1_q;
         assign rdata_o  = rd1_q;
      end
   endgenerate

endmodule

// File: tb/tb_sp_ram_banked_pm.sv
// Directed bench for sp_ram_banked_pm: default instance plus OUT_REG=1 and
// IDLE_CYCLES=0 instances sharing one stimulus bus.
module tb_sp_ram_banked_pm;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_i, req_i, we_i;
   logic [14:0] addr_i;
   logic [3:0]  be_i;
   logic [31:0] wdata_i;

   logic        gnt_o, rvalid_o, gnt_r, rvalid_r, gnt_n, rvalid_n;
   logic [31:0] rdata_o, rdata_r, rdata_n;
   logic [3:0]  bank_awake_o, bank_awake_r, bank_awake_n;

   sp_ram_banked_pm u_dut (
      .clk(clk), .rst_i(rst_i), .req_i(req_i), .gnt_o(gnt_o), .addr_i(addr_i),
      .we_i(we_i), .be_i(be_i), .wdata_i(wdata_i), .rvalid_o(rvalid_o),
      .rdata_o(rdata_o), .bank_awake_o(bank_awake_o)
   );

   sp_ram_banked_pm #(.OUT_REG(1)) u_dut_r (
      .clk(clk), .rst_i(rst_i), .req_i(req_i), .gnt_o(gnt_r), .addr_i(addr_i),
      .we_i(we_i), .be_i(be_i), .wdata_i(wdata_i), .rvalid_o(rvalid_r),
      .rdata_o(rdata_r), .bank_awake_o(bank_awake_r)
   );

   sp_ram_banked_pm #(.IDLE_CYCLES(0)) u_dut_n (
      .clk(clk), .rst_i(rst_i), .req_i(req_i), .gnt_o(gnt_n), .addr_i(addr_i),
      .we_i(we_i), .be_i(be_i), .wdata_i(wdata_i), .rvalid_o(rvalid_n),
      .rdata_o(rdata_n), .bank_awake_o(bank_awake_n)
   );

   int n_chk  = 0;
   int n_pass = 0;

   logic [14:0] ba [4] = '{15'h0000, 15'h2004, 15'h4008, 15'h6000};
   logic [31:0] bd [4] = '{32'hDEADBEEF, 32'h11BB33DD, 32'h55667788, 32'hCAFEF00D};

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
   endtask

   // Inputs change 1 ns after the rising edge, outputs are sampled 2 ns after it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_acc(input logic we, input logic [14:0] a, input logic [3:0] be,
                         input logic [31:0] wd, output int stall);
      stall = 0;
      tick();
      req_i = 1'b1; we_i = we; addr_i = a; be_i = be; wdata_i = wd;
      #1;
      while (!gnt_o && stall < 8) begin
         tick();
         #1;
         stall++;
      end
      if (!gnt_o) chk("gnt_timeout", gnt_o, 1);
   endtask

   task automatic wr(input string tag, input logic [14:0] a, input logic [3:0] be,
                     input logic [31:0] wd, input int exp_stall);
      int st;
      do_acc(1'b1, a, be, wd, st);
      if (exp_stall >= 0) chk({tag, "_stall"}, st, exp_stall);
   endtask

   task automatic rd_chk(input string tag, input logic [14:0] a, input logic [31:0] exp,
                         input int exp_stall);
      int st;
      do_acc(1'b0, a, 4'h0, 32'h0, st);
      chk({tag, "_stall"}, st, exp_stall);
      tick();
      req_i = 1'b0;
      #1;
      chk({tag, "_rv"}, rvalid_o, 1);
      chk({tag, "_rd"}, rdata_o, exp);
      chk({tag, "_rv_r_early"}, rvalid_r, 0);
      chk({tag, "_rv_n"}, rvalid_n, 1);
      chk({tag, "_rd_n"}, rdata_n, exp);
      tick();
      #1;
      chk({tag, "_rv_end"}, rvalid_o, 0);
      chk({tag, "_rd_hold"}, rdata_o, exp);
      chk({tag, "_rv_r"}, rvalid_r, 1);
      chk({tag, "_rd_r"}, rdata_r, exp);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         tick();
         req_i = 1'b0;
      end
   endtask

   initial begin
      int bad;
      rst_i = 1'b1; req_i = 1'b0; we_i = 1'b0; addr_i = '0; be_i = '0; wdata_i = '0;
      repeat (3) tick();
      rst_i = 1'b0;
      req_i = 1'b1; we_i = 1'b1; addr_i = 15'h4000; be_i = 4'h0;
      #1;
      chk("rst_rvalid", rvalid_o, 0);
      chk("rst_rdata", rdata_o, 0);
      chk("rst_rdata_r", rdata_r, 0);
      chk("rst_awake", bank_awake_o, 4'hF);
      chk("rst_awake_r", bank_awake_r, 4'hF);
      chk("rst_gnt", gnt_o, 1);

      wr("w4008", 15'h4008, 4'hF, 32'h55667788, 0);

      // Full write then read-after-write on bank 0.
      wr("t1_wr", 15'h0000, 4'hF, 32'hDEADBEEF, 0);
      rd_chk("t1", 15'h0000, 32'hDEADBEEF, 0);

      // Byte-enable merge on bank 1, then an all-zero byte-enable write.
      wr("t2_wr", 15'h2004, 4'hF, 32'h11223344, 0);
      wr("t2_wrbe", 15'h2004, 4'b0101, 32'hAABBCCDD, 0);
      rd_chk("t2", 15'h2004, 32'h11BB33DD, 0);
      wr("t2_be0", 15'h2004, 4'h0, 32'hFFFFFFFF, 0);
      rd_chk("t2_be0", 15'h2004, 32'h11BB33DD, 0);

      // Bank 3 sleeps after exactly 16 unaccessed cycles, then wakes on demand.
      wr("t3_wr", 15'h6000, 4'hF, 32'hCAFEF00D, 0);
      for (int i = 1; i <= 16; i++) begin
         tick();
         req_i = 1'b0;
         #1;
         if (i == 16) chk("t3_awake_last", bank_awake_o[3], 1);
      end
      tick();
      #1;
      chk("t3_asleep", bank_awake_o[3], 0);
      chk("t3_asleep_r", bank_awake_r[3], 0);
      chk("t3_noidle_awake", bank_awake_n, 4'hF);
      rd_chk("t3", 15'h6000, 32'hCAFEF00D, 3);

      // Wake every bank, then a back-to-back read burst across all four.
      wr("t4_wake0", 15'h0000, 4'h0, 32'h0, 3);
      wr("t4_wake1", 15'h2004, 4'h0, 32'h0, 3);
      wr("t4_wake2", 15'h4008, 4'h0, 32'h0, 3);
      wr("t4_wake3", 15'h6000, 4'h0, 32'h0, -1);
      for (int i = 0; i < 6; i++) begin
         tick();
         if (i < 4) begin
            req_i = 1'b1; we_i = 1'b0; addr_i = ba[i];
         end else begin
            req_i = 1'b0;
         end
         #1;
         if (i < 4) begin
            chk("t4_gnt", gnt_o, 1);
            chk("t4_gnt_r", gnt_r, 1);
         end
         if (i >= 1 && i <= 4) begin
            chk("t4_rv", rvalid_o, 1);
            chk("t4_rd", rdata_o, bd[i-1]);
         end
         if (i >= 2) begin
            chk("t4_rv_r", rvalid_r, 1);
            chk("t4_rd_r", rdata_r, bd[i-2]);
         end
         if (i == 5) chk("t4_rv_end", rvalid_o, 0);
      end
      chk("t4_awake", bank_awake_o, 4'hF);

      // Reset while bank 2 wakes and reads are in flight. The wake request is
      // withdrawn so that a bank 0 read can be granted during the wake.
      idle(20);
      #1;
      chk("t5_all_sleep", bank_awake_o, 4'h0);
      wr("t5_wake0", 15'h0000, 4'h0, 32'h0, 3);
      tick();
      req_i = 1'b1; we_i = 1'b0; addr_i = 15'h4008;
      #1;
      chk("t5_wake_req_gnt", gnt_o, 0);
      tick();
      addr_i = 15'h0000;
      #1;
      chk("t5_rd0_gnt", gnt_o, 1);
      chk("t5_waking", bank_awake_o, 4'b0001);
      tick();
      rst_i = 1'b1;
      #1;
      chk("t5_pre_rv", rvalid_o, 1);
      chk("t5_pre_rd", rdata_o, 32'hDEADBEEF);
      chk("t5_pre_rv_r", rvalid_r, 0);
      chk("t5_pre_waking", bank_awake_o, 4'b0001);
      tick();
      rst_i = 1'b0;
      req_i = 1'b0;
      #1;
      chk("t5_rv", rvalid_o, 0);
      chk("t5_rd", rdata_o, 0);
      chk("t5_rv_r", rvalid_r, 0);
      chk("t5_rd_r", rdata_r, 0);
      chk("t5_awake", bank_awake_o, 4'hF);
      chk("t5_awake_r", bank_awake_r, 4'hF);
      tick();
      #1;
      chk("t5_late_rv", rvalid_o, 0);
      chk("t5_late_rv_r", rvalid_r, 0);
      rd_chk("t5_post", 15'h4008, 32'h55667788, 0);

      // Sleep disabled: 1000 idle cycles never drop a bank.
      bad = 0;
      for (int i = 0; i < 1000; i++) begin
         tick();
         req_i = 1'b0;
         #1;
         if (bank_awake_n !== 4'hF) bad++;
      end
      chk("t6_noidle_drops", bad, 0);
      chk("t6_noidle_final", bank_awake_n, 4'hF);
      chk("t6_noidle_rv", rvalid_n, 0);
      chk("t6_dflt_sleep", bank_awake_o, 4'h0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
